// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Byte-enable and alignment helpers used by the lane aligner and the FSM.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Size 2'b11 falls into the default branch and behaves as a word.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 4'b0001 << lane;
            SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane handling: store replication and byte enables,
// load lane extraction with sign/zero extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_lane,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_lane,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_be = lane_be(st_size, st_lane);
        case (st_size)
            SZ_BYTE: st_wdata = {4{st_data[7:0]}};
            SZ_HALF: st_wdata = {2{st_data[15:0]}};
            default: st_wdata = st_data;
        endcase
    end

    always_comb begin
        ld_byte = rdata[{ld_lane, 3'b000} +: 8];
        ld_half = ld_lane[1] ? rdata[31:16] : rdata[15:0];
        case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage driving a req/ack data bus and stalling the core.
// Optional macro LSU_ALIGN_CHECK_EN aborts misaligned half/word accesses without a bus cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic                  op_write,
    input  logic [1:0]            op_size,
    input  logic                  op_unsigned,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [31:0]           op_wdata,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state, state_nx;
    logic        wr_q, uns_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [15:0] cnt;
    logic        timeout;
    logic        bad_align;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_ext;

    lsu_lane_align u_lane_align (
        .st_size     (op_size),
        .st_lane     (op_addr[1:0]),
        .st_data     (op_wdata),
        .st_be       (st_be),
        .st_wdata    (st_wdata),
        .ld_size     (size_q),
        .ld_lane     (lane_q),
        .ld_unsigned (uns_q),
        .rdata       (mem_rdata),
        .ld_data     (ld_ext)
    );

`ifdef LSU_ALIGN_CHECK_EN
    assign bad_align = is_misaligned(op_size, op_addr[1:0]);
`else
    assign bad_align = 1'b0;
`endif

    assign timeout = (cnt == TO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // An ack arriving on the timeout cycle takes priority over the abort.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (op_valid) state_nx = bad_align ? DONE : REQ;
            REQ:     if (mem_ack || timeout) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        load_valid = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: stall = op_valid & ~rst;
            REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = wr_q;
            end
            DONE: begin
                load_valid = ~wr_q & ~err_q;
                err        = err_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            uns_q     <= 1'b0;
            err_q     <= 1'b0;
            size_q    <= '0;
            lane_q    <= '0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: if (op_valid) begin
                    wr_q      <= op_write;
                    uns_q     <= op_unsigned;
                    size_q    <= op_size;
                    lane_q    <= op_addr[1:0];
                    cnt       <= '0;
                    mem_addr  <= {op_addr[ADDR_WIDTH-1:2], 2'b00};
                    mem_be    <= st_be;
                    mem_wdata <= st_wdata;
                    err_q     <= bad_align;
                    if (bad_align) load_data <= '0;
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!wr_q) load_data <= ld_ext;
                    end else if (timeout) begin
                        err_q     <= 1'b1;
                        load_data <= '0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (TIMEOUT_CYCLES = 8).
// Honours LSU_ALIGN_CHECK_EN for the misaligned-word case.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid, op_write, op_unsigned;
    logic [1:0]  op_size;
    logic [31:0] op_addr, op_wdata;
    logic        stall, load_valid, err, mem_req, mem_we, mem_ack;
    logic [31:0] load_data, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_ld = '0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_write(op_write),
        .op_size(op_size), .op_unsigned(op_unsigned), .op_addr(op_addr),
        .op_wdata(op_wdata), .stall(stall), .load_data(load_data),
        .load_valid(load_valid), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned waits;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_ldata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int unsigned waits, input logic [31:0] rdata,
                                input logic [31:0] ea, input logic [3:0] ebe,
                                input logic [31:0] ew, input logic [31:0] eld);
        vec_t v;
        v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.waits = waits; v.rdata = rdata; v.exp_addr = ea; v.exp_be = ebe;
        v.exp_wdata = ew; v.exp_ldata = eld;
        return v;
    endfunction

    task automatic start_op(input logic wr, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        op_valid = 1'b1; op_write = wr; op_size = size; op_unsigned = uns;
        op_addr = addr; op_wdata = wdata;
        #1;
    endtask

    task automatic run_access(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        start_op(v.wr, v.size, v.uns, v.addr, v.wdata);
        chk({tag, ".idle_stall"}, stall, 1'b1);
        chk({tag, ".idle_req"}, mem_req, 1'b0);
        for (int unsigned k = 0; k <= v.waits; k++) begin
            @(negedge clk);
            mem_ack = (k == v.waits);
            mem_rdata = (k == v.waits) ? v.rdata : 32'h5A5A_5A5A;
            #1;
            chk({tag, ".req"}, mem_req, 1'b1);
            chk({tag, ".stall"}, stall, 1'b1);
            chk({tag, ".we"}, mem_we, v.wr);
            chk({tag, ".addr"}, mem_addr, v.exp_addr);
            chk({tag, ".be"}, {28'd0, mem_be}, {28'd0, v.exp_be});
            if (v.wr) chk({tag, ".wdata"}, mem_wdata, v.exp_wdata);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        if (!v.wr) exp_ld = v.exp_ldata;
        chk({tag, ".done_stall"}, stall, 1'b0);
        chk({tag, ".done_req"}, mem_req, 1'b0);
        chk({tag, ".load_valid"}, load_valid, !v.wr);
        chk({tag, ".err"}, err, 1'b0);
        chk({tag, ".load_data"}, load_data, exp_ld);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        chk({tag, ".after_lv"}, load_valid, 1'b0);
        chk({tag, ".after_req"}, mem_req, 1'b0);
    endtask

    initial begin
        rst = 1'b1; op_valid = 1'b0; op_write = 1'b0; op_size = 2'b00; op_unsigned = 1'b0;
        op_addr = '0; op_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;

        tbl.push_back(mk(0, 2'b00, 0, 32'h1003, 32'h0, 0, 32'h8011_2233, 32'h1000, 4'b1000, 32'h0, 32'hFFFF_FF80));
        tbl.push_back(mk(1, 2'b01, 0, 32'h2002, 32'h1234_BEEF, 0, 32'h0, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0));
        tbl.push_back(mk(0, 2'b01, 1, 32'h3002, 32'h0, 3, 32'hF00D_1234, 32'h3000, 4'b1100, 32'h0, 32'h0000_F00D));
        tbl.push_back(mk(0, 2'b00, 1, 32'h0005, 32'h0, 1, 32'h1122_3344, 32'h0004, 4'b0010, 32'h0, 32'h0000_0033));
        tbl.push_back(mk(0, 2'b00, 0, 32'h0006, 32'h0, 0, 32'h11A2_3344, 32'h0004, 4'b0100, 32'h0, 32'hFFFF_FFA2));
        tbl.push_back(mk(0, 2'b01, 0, 32'h0010, 32'h0, 0, 32'h1234_8001, 32'h0010, 4'b0011, 32'h0, 32'hFFFF_8001));
        tbl.push_back(mk(1, 2'b00, 0, 32'h0021, 32'hDEAD_BE5A, 0, 32'h0, 32'h0020, 4'b0010, 32'h5A5A_5A5A, 32'h0));
        tbl.push_back(mk(1, 2'b10, 0, 32'h0030, 32'h0123_4567, 2, 32'h0, 32'h0030, 4'b1111, 32'h0123_4567, 32'h0));
        tbl.push_back(mk(0, 2'b11, 0, 32'h0040, 32'h0, 0, 32'h89AB_CDEF, 32'h0040, 4'b1111, 32'h0, 32'h89AB_CDEF));
        tbl.push_back(mk(0, 2'b00, 0, 32'h0000, 32'h0, 0, 32'h0000_007F, 32'h0000, 4'b0001, 32'h0, 32'h0000_007F));
        tbl.push_back(mk(0, 2'b10, 0, 32'h0050, 32'h0, 7, 32'h55AA_55AA, 32'h0050, 4'b1111, 32'h0, 32'h55AA_55AA));
`ifndef LSU_ALIGN_CHECK_EN
        tbl.push_back(mk(0, 2'b10, 0, 32'h1001, 32'h0, 0, 32'hCAFE_F00D, 32'h1000, 4'b1111, 32'h0, 32'hCAFE_F00D));
`endif

        // Reset state
        #12;
        chk("rst.stall", stall, 1'b0);
        chk("rst.req", mem_req, 1'b0);
        chk("rst.we", mem_we, 1'b0);
        chk("rst.addr", mem_addr, 32'h0);
        chk("rst.be", {28'd0, mem_be}, 32'h0);
        chk("rst.wdata", mem_wdata, 32'h0);
        chk("rst.load_data", load_data, 32'h0);
        chk("rst.lv", load_valid, 1'b0);
        chk("rst.err", err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Stray ack while idle must be ignored
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_DEAD;
        #1;
        chk("stray.stall", stall, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk("stray.req", mem_req, 1'b0);
        chk("stray.lv", load_valid, 1'b0);
        chk("stray.load_data", load_data, 32'h0);

        foreach (tbl[i]) run_access(i, tbl[i]);

        // Timeout: lw 0x4000, never acked, 8 REQ cycles then abort
        start_op(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
        chk("to.idle_stall", stall, 1'b1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("to.req%0d", k), mem_req, 1'b1);
        end
        @(negedge clk);
        #1;
        exp_ld = '0;
        chk("to.req_drop", mem_req, 1'b0);
        chk("to.err", err, 1'b1);
        chk("to.lv", load_valid, 1'b0);
        chk("to.stall", stall, 1'b0);
        chk("to.load_data", load_data, exp_ld);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("to.err_pulse", err, 1'b0);
        chk("to.idle_req", mem_req, 1'b0);

`ifdef LSU_ALIGN_CHECK_EN
        // Misaligned word: straight to DONE with err, no bus request
        start_op(1'b0, 2'b10, 1'b0, 32'h1001, 32'h0);
        chk("mis.stall", stall, 1'b1);
        chk("mis.req0", mem_req, 1'b0);
        @(negedge clk);
        #1;
        exp_ld = '0;
        chk("mis.req1", mem_req, 1'b0);
        chk("mis.err", err, 1'b1);
        chk("mis.lv", load_valid, 1'b0);
        chk("mis.stall_done", stall, 1'b0);
        chk("mis.load_data", load_data, exp_ld);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("mis.err_pulse", err, 1'b0);
`endif

        // Async reset in the middle of a REQ
        start_op(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0);
        @(negedge clk);
        #1;
        chk("arst.req_before", mem_req, 1'b1);
        #1;
        rst = 1'b1;
        op_valid = 1'b0;
        #1;
        exp_ld = '0;
        chk("arst.req", mem_req, 1'b0);
        chk("arst.stall", stall, 1'b0);
        chk("arst.lv", load_valid, 1'b0);
        chk("arst.err", err, 1'b0);
        chk("arst.addr", mem_addr, 32'h0);
        chk("arst.load_data", load_data, exp_ld);
        @(negedge clk);
        rst = 1'b0;
        run_access(99, mk(0, 2'b00, 1, 32'h7001, 32'h0, 0, 32'h0000_AB00, 32'h7000, 4'b0010, 32'h0, 32'h0000_00AB));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
